// File: rtl/dm_arb.sv
// Two-port arbiter sharing the single-ported data memory between the CPU (port 0) and DMA/debug (port 1).
// Define DM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
//   state | meaning
//   IDLE  | no captured command, dm write disabled
//   ACC   | captured command drives dm this cycle
module dm_arb #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wd,
    input  logic [1:0]    p0_byteExt,
    output logic          p0_gnt,
    output logic          p0_done,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wd,
    input  logic [1:0]    p1_byteExt,
    output logic          p1_gnt,
    output logic          p1_done,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] dm_addr,
    output logic          dm_wE,
    output logic [DW-1:0] dm_wd,
    output logic [1:0]    dm_byteExt,
    input  logic [DW-1:0] dm_rd
);

    typedef enum logic {IDLE, ACC} state_t;

    state_t        state_q, state_d;
    logic          any_req;
    logic          win1;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wd;
    logic [1:0]    cmd_be;
    logic          cmd_own;
    logic          in_acc;

    assign any_req = p0_req | p1_req;
    assign in_acc  = (state_q == ACC);

`ifdef DM_ARB_FIXED_PRIO_EN
    assign win1 = p1_req & ~p0_req;
`else
    // last_q = 1 means port 1 won most recently, so port 0 takes the next tie
    logic last_q;

    assign win1 = p1_req & (~p0_req | ~last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (any_req) begin
            last_q <= win1;
        end
    end
`endif

    assign p0_gnt = rst_n & p0_req & ~win1;
    assign p1_gnt = rst_n & win1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dm_wE   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = ACC;
            end
            ACC: begin
                dm_wE = cmd_we;
                if (!any_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_we   <= 1'b0;
            cmd_addr <= '0;
            cmd_wd   <= '0;
            cmd_be   <= 2'b00;
            cmd_own  <= 1'b0;
        end else if (any_req) begin
            cmd_we   <= win1 ? p1_we      : p0_we;
            cmd_addr <= win1 ? p1_addr    : p0_addr;
            cmd_wd   <= win1 ? p1_wd      : p0_wd;
            cmd_be   <= win1 ? p1_byteExt : p0_byteExt;
            cmd_own  <= win1;
        end
    end

    assign dm_addr    = cmd_addr;
    assign dm_wd      = cmd_wd;
    assign dm_byteExt = cmd_be;

    // Completion and read data land one cycle after the access, only for the owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_done  <= 1'b0;
            p1_done  <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            p0_done <= in_acc & ~cmd_own;
            p1_done <= in_acc & cmd_own;
            if (in_acc && !cmd_own) p0_rdata <= dm_rd;
            if (in_acc && cmd_own)  p1_rdata <= dm_rd;
        end
    end

endmodule

// File: tb/tb_dm_arb.sv
// Directed bench for dm_arb with a behavioural byte-addressable dm model.
// Expectations follow DM_ARB_FIXED_PRIO_EN when the build defines it.
module tb_dm_arb;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wd, p1_wd;
    logic [1:0]    p0_byteExt, p1_byteExt;
    logic          p0_gnt, p1_gnt, p0_done, p1_done;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] dm_addr;
    logic          dm_wE;
    logic [DW-1:0] dm_wd;
    logic [1:0]    dm_byteExt;
    logic [DW-1:0] dm_rd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dm_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wd(p0_wd),
        .p0_byteExt(p0_byteExt), .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wd(p1_wd),
        .p1_byteExt(p1_byteExt), .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .dm_addr(dm_addr), .dm_wE(dm_wE), .dm_wd(dm_wd), .dm_byteExt(dm_byteExt),
        .dm_rd(dm_rd)
    );

    // Memory model: little-endian, byteExt 00 lbu / 01 lb / 1x word on reads,
    // 11 word store, anything else a byte store of wd[7:0].
    logic [31:0] mem [0:1023];
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic        pl_en = 1'b0;
    logic [9:0]  pl_a = '0;
    logic [31:0] pl_d = '0;

    always_comb begin
        rd_word = mem[dm_addr[11:2]];
        rd_byte = rd_word[8*dm_addr[1:0] +: 8];
        case (dm_byteExt)
            2'b00:   dm_rd = {24'h0, rd_byte};
            2'b01:   dm_rd = {{24{rd_byte[7]}}, rd_byte};
            default: dm_rd = rd_word;
        endcase
    end

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_a] <= pl_d;
        end else if (dm_wE) begin
            if (dm_byteExt == 2'b11) mem[dm_addr[11:2]] <= dm_wd;
            else mem[dm_addr[11:2]][8*dm_addr[1:0] +: 8] <= dm_wd[7:0];
        end
    end

    typedef struct {
        logic        r0, w0;
        logic [11:0] a0;
        logic [1:0]  b0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [11:0] a1;
        logic [1:0]  b1;
        logic [31:0] d1;
        logic        eg0, eg1, ed0, ed1, ck0, ck1;
        logic [31:0] er0, er1;
    } vec_t;

    function automatic vec_t mk(
        input logic r0, input logic w0, input logic [11:0] a0, input logic [1:0] b0, input logic [31:0] d0,
        input logic r1, input logic w1, input logic [11:0] a1, input logic [1:0] b1, input logic [31:0] d1,
        input logic eg0, input logic eg1, input logic ed0, input logic ed1,
        input logic ck0, input logic [31:0] er0, input logic ck1, input logic [31:0] er1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.b0 = b0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.b1 = b1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.ed0 = ed0; v.ed1 = ed1;
        v.ck0 = ck0; v.er0 = er0; v.ck1 = ck1; v.er1 = er1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wd = '0; p0_byteExt = 2'b00;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wd = '0; p1_byteExt = 2'b00;
    endtask

    task automatic drive0(input logic we, input logic [11:0] a, input logic [1:0] be, input logic [31:0] d);
        p0_req = 1; p0_we = we; p0_addr = a; p0_byteExt = be; p0_wd = d;
    endtask

    task automatic drive1(input logic we, input logic [11:0] a, input logic [1:0] be, input logic [31:0] d);
        p1_req = 1; p1_we = we; p1_addr = a; p1_byteExt = be; p1_wd = d;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_in();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic run_tbl(input string tag, input vec_t t[$]);
        for (int i = 0; i < t.size(); i++) begin
            @(posedge clk);
            #1;
            p0_req = t[i].r0; p0_we = t[i].w0; p0_addr = t[i].a0; p0_byteExt = t[i].b0; p0_wd = t[i].d0;
            p1_req = t[i].r1; p1_we = t[i].w1; p1_addr = t[i].a1; p1_byteExt = t[i].b1; p1_wd = t[i].d1;
            @(negedge clk);
            chk($sformatf("%s[%0d] p0_gnt", tag, i), {31'b0, p0_gnt}, {31'b0, t[i].eg0});
            chk($sformatf("%s[%0d] p1_gnt", tag, i), {31'b0, p1_gnt}, {31'b0, t[i].eg1});
            chk($sformatf("%s[%0d] p0_done", tag, i), {31'b0, p0_done}, {31'b0, t[i].ed0});
            chk($sformatf("%s[%0d] p1_done", tag, i), {31'b0, p1_done}, {31'b0, t[i].ed1});
            chk($sformatf("%s[%0d] both_done", tag, i), {31'b0, p0_done & p1_done}, 32'h0);
            if (t[i].ck0) chk($sformatf("%s[%0d] p0_rdata", tag, i), p0_rdata, t[i].er0);
            if (t[i].ck1) chk($sformatf("%s[%0d] p1_rdata", tag, i), p1_rdata, t[i].er1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tb_b[$];
        vec_t tb_c[$];

        idle_in();
        rst_n = 0;
        p0_req = 1;
        p0_addr = 12'h010;
        @(posedge clk); #1;
        pl_en = 1;
        pl_a = 10'd4; pl_d = 32'h11223344; @(posedge clk); #1;
        pl_a = 10'd5; pl_d = 32'h01020304; @(posedge clk); #1;
        pl_a = 10'd6; pl_d = 32'h00008000; @(posedge clk); #1;
        pl_a = 10'd8; pl_d = 32'hA0A0A0A0; @(posedge clk); #1;
        pl_a = 10'd9; pl_d = 32'hB1B1B1B1; @(posedge clk); #1;
        pl_en = 0;
        @(negedge clk);
        chk("rst p0_gnt", {31'b0, p0_gnt}, 32'h0);
        chk("rst dm_addr", {20'b0, dm_addr}, 32'h0);
        chk("rst dm_wE", {31'b0, dm_wE}, 32'h0);
        chk("rst dm_wd", dm_wd, 32'h0);
        chk("rst dm_byteExt", {30'b0, dm_byteExt}, 32'h0);
        chk("rst done", {30'b0, p1_done, p0_done}, 32'h0);
        chk("rst p0_rdata", p0_rdata, 32'h0);
        chk("rst p1_rdata", p1_rdata, 32'h0);
        idle_in();
        rst_n = 1;

        // p1 byte store over 0x11223344, then p0 lbu of the same byte sees the new value
        tb_b.push_back(mk(0,0,12'h000,2'b00,0, 1,1,12'h013,2'b10,32'h0000005A, 0,1,0,0, 0,0,0,0));
        tb_b.push_back(mk(1,0,12'h013,2'b00,0, 0,0,12'h000,2'b00,0,            1,0,0,0, 0,0,0,0));
        tb_b.push_back(mk(0,0,12'h000,2'b00,0, 0,0,12'h000,2'b00,0,            0,0,0,1, 0,0,0,0));
        tb_b.push_back(mk(0,0,12'h000,2'b00,0, 0,0,12'h000,2'b00,0,            0,0,1,0, 1,32'h0000005A,0,0));
        run_tbl("sb_lbu", tb_b);
        chk("sb mem word", mem[4], 32'h5A223344);

        // p0 word store: gnt in cycle 0, access in 1, done in 2
        @(posedge clk); #1;
        drive0(1, 12'h010, 2'b11, 32'hDEADBEEF);
        @(negedge clk);
        chk("st p0_gnt", {31'b0, p0_gnt}, 32'h1);
        chk("st p1_gnt", {31'b0, p1_gnt}, 32'h0);
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        chk("st dm_wE", {31'b0, dm_wE}, 32'h1);
        chk("st dm_addr", {20'b0, dm_addr}, 32'h010);
        chk("st dm_wd", dm_wd, 32'hDEADBEEF);
        chk("st p0_done early", {31'b0, p0_done}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("st p0_done", {31'b0, p0_done}, 32'h1);
        chk("st dm_wE idle", {31'b0, dm_wE}, 32'h0);
        chk("st mem", mem[4], 32'hDEADBEEF);
        @(posedge clk); #1;
        drive0(0, 12'h010, 2'b11, 32'h0);
        @(negedge clk);
        chk("ld p0_gnt", {31'b0, p0_gnt}, 32'h1);
        @(posedge clk); #1;
        idle_in();
        @(posedge clk); #1;
        @(negedge clk);
        chk("ld p0_done", {31'b0, p0_done}, 32'h1);
        chk("ld p0_rdata", p0_rdata, 32'hDEADBEEF);

        // Sustained contention: both ports load every cycle for 8 cycles
        do_reset();
        for (int k = 0; k < 10; k++) begin
            logic rq, eg0, eg1, ed0, ed1;
            rq = (k < 8);
`ifdef DM_ARB_FIXED_PRIO_EN
            eg0 = rq;
            eg1 = 1'b0;
            ed0 = (k >= 2);
            ed1 = 1'b0;
`else
            eg0 = rq && (k % 2 == 0);
            eg1 = rq && (k % 2 == 1);
            ed0 = (k >= 2) && (k % 2 == 0);
            ed1 = (k >= 2) && (k % 2 == 1);
`endif
            tb_c.push_back(mk(rq,0,12'h020,2'b11,0, rq,0,12'h024,2'b11,0,
                              eg0,eg1,ed0,ed1, ed0,32'hA0A0A0A0, ed1,32'hB1B1B1B1));
        end
        run_tbl("contend", tb_c);

        // Reset during the ACC cycle of a store: write suppressed, no done
        do_reset();
        @(posedge clk); #1;
        drive0(1, 12'h014, 2'b11, 32'hCAFEF00D);
        @(negedge clk);
        chk("racc p0_gnt", {31'b0, p0_gnt}, 32'h1);
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        chk("racc dm_wE before", {31'b0, dm_wE}, 32'h1);
        #1;
        rst_n = 0;
        #1;
        chk("racc dm_wE after", {31'b0, dm_wE}, 32'h0);
        chk("racc dm_addr", {20'b0, dm_addr}, 32'h0);
        chk("racc dm_wd", dm_wd, 32'h0);
        @(posedge clk); #1;
        chk("racc p0_done", {31'b0, p0_done}, 32'h0);
        chk("racc mem", mem[5], 32'h01020304);
        @(posedge clk); #1;
        chk("racc p0_done2", {31'b0, p0_done}, 32'h0);
        chk("racc p0_rdata", p0_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1;

        // p0 word load then p1 lb of 0x80: sign extension, p0_rdata untouched
        @(posedge clk); #1;
        drive0(0, 12'h018, 2'b11, 32'h0);
        @(negedge clk);
        chk("lb p0_gnt", {31'b0, p0_gnt}, 32'h1);
        @(posedge clk); #1;
        idle_in();
        drive1(0, 12'h019, 2'b01, 32'h0);
        @(negedge clk);
        chk("lb p1_gnt", {31'b0, p1_gnt}, 32'h1);
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        chk("lb p0_done", {31'b0, p0_done}, 32'h1);
        chk("lb p0_rdata", p0_rdata, 32'h00008000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lb p1_done", {31'b0, p1_done}, 32'h1);
        chk("lb p0_done off", {31'b0, p0_done}, 32'h0);
        chk("lb p1_rdata", p1_rdata, 32'hFFFFFF80);
        chk("lb p0_rdata hold", p0_rdata, 32'h00008000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
